// File: rtl/args_regbank.sv
// ---------------------------------------------------------------------------
// args_regbank
//
// Small memory-mapped register bank. Each of the NU registers is DW bits wide
// and lives at byte address BA + i*(DW/8). Each register has a type taken from
// the 2-bit field TP[2*i +: 2]:
//   2'b00  RO        - read returns rregs slice sampled in the ren cycle
//   2'b01  RW        - byte-strobed writes, reset value from DV slice
//   2'b10  W1C       - rregs bits set, write-one clears, set wins
//   2'b11  reserved  - behaves as RO
//
// Optional feature (compile-time macro ARGS_REGBANK_SHADOW_EN):
//   Adds input 'commit'. RW writes then land in a shadow copy, reads return
//   the shadow, and wregs only loads the shadows on an edge with commit=1.
//   A commit in the same cycle as a write publishes the pre-write shadow.
//
// Ports
//   clk     in   1         clock, the only clock domain
//   rst     in   1         asynchronous active-high reset
//   commit  in   1         publish shadows to wregs (only with the macro)
//   rregs   in   DW*NU     RO values / W1C set pulses
//   wregs   out  DW*NU     RW register values, RO and W1C slices are 0
//   wen     in   1         write request
//   waddr   in   AW        write byte address
//   wdata   in   DW        write data
//   wstrb   in   DW/8      write byte enables
//   werr    out  1         one-cycle pulse on a write miss
//   ren     in   1         read request, accepted every cycle
//   raddr   in   AW        read byte address
//   rvalid  out  1         read data valid, one cycle after ren
//   rdata   out  DW        registered read data, held while rvalid=0
//   rerr    out  1         read miss, qualified by rvalid
//   irq     out  1         registered OR of all W1C bits
// ---------------------------------------------------------------------------
module args_regbank #(
    parameter int unsigned          BA = 16'h0000,
    parameter int                   NU = 4,
    parameter int                   AW = 32,
    parameter int                   DW = 32,
    parameter logic [2*NU-1:0]      TP = {NU{2'b01}},
    parameter logic [DW*NU-1:0]     DV = '0
) (
    input  logic                clk,
    input  logic                rst,
`ifdef ARGS_REGBANK_SHADOW_EN
    input  logic                commit,
`endif
    input  logic [DW*NU-1:0]    rregs,
    output logic [DW*NU-1:0]    wregs,
    input  logic                wen,
    input  logic [AW-1:0]       waddr,
    input  logic [DW-1:0]       wdata,
    input  logic [DW/8-1:0]     wstrb,
    output logic                werr,
    input  logic                ren,
    input  logic [AW-1:0]       raddr,
    output logic                rvalid,
    output logic [DW-1:0]       rdata,
    output logic                rerr,
    output logic                irq
);

    localparam int         NB    = DW / 8;
    localparam logic [1:0] T_RW  = 2'b01;
    localparam logic [1:0] T_W1C = 2'b10;

    // Per-register decode results and read-back values
    logic [NU-1:0] whit;
    logic [NU-1:0] rhit;
    logic [NU-1:0] w1c_any;
    logic [DW-1:0] rd_val [NU];

    // Byte strobes expanded to a bit mask
    logic [DW-1:0] wmask;

    genvar gi;

    generate
        for (gi = 0; gi < NB; gi++) begin : g_mask
            assign wmask[gi*8 +: 8] = {8{wstrb[gi]}};
        end
    endgenerate

    generate
        for (gi = 0; gi < NU; gi++) begin : g_reg
            localparam logic [1:0]    TYPE = TP[2*gi +: 2];
            // Exact-match decode: any misaligned or out-of-range address
            // simply matches no register.
            localparam logic [AW-1:0] ADDR = AW'(BA) + AW'(gi * NB);

            assign whit[gi] = (waddr == ADDR);
            assign rhit[gi] = (raddr == ADDR);

            if (TYPE == T_RW) begin : g_rw
                localparam logic [DW-1:0] RST_VAL = DV[gi*DW +: DW];

                // In shadow builds val_q is the shadow copy; otherwise it is
                // the live register driven onto wregs.
                logic [DW-1:0] val_q;
                logic [DW-1:0] val_d;
                logic          unused_rregs;

                always_comb begin
                    val_d = val_q;
                    if (wen && whit[gi]) begin
                        val_d = (val_q & ~wmask) | (wdata & wmask);
                    end
                end

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        val_q <= RST_VAL;
                    end else begin
                        val_q <= val_d;
                    end
                end

`ifdef ARGS_REGBANK_SHADOW_EN
                logic [DW-1:0] out_q;
                logic [DW-1:0] out_d;

                // Commit samples val_q (pre-write), so a write in the same
                // cycle only becomes visible on a later commit.
                always_comb begin
                    out_d = out_q;
                    if (commit) begin
                        out_d = val_q;
                    end
                end

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        out_q <= RST_VAL;
                    end else begin
                        out_q <= out_d;
                    end
                end

                assign wregs[gi*DW +: DW] = out_q;
`else
                assign wregs[gi*DW +: DW] = val_q;
`endif
                assign rd_val[gi]   = val_q;
                assign w1c_any[gi]  = 1'b0;
                assign unused_rregs = ^rregs[gi*DW +: DW];
            end else if (TYPE == T_W1C) begin : g_w1c
                logic [DW-1:0] val_q;
                logic [DW-1:0] val_d;
                logic [DW-1:0] clr;

                // Clear is applied first and the set OR-ed in afterwards,
                // so a simultaneous set and clear leaves the bit set.
                always_comb begin
                    clr = '0;
                    if (wen && whit[gi]) begin
                        clr = wdata & wmask;
                    end
                    val_d = (val_q & ~clr) | rregs[gi*DW +: DW];
                end

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        val_q <= '0;
                    end else begin
                        val_q <= val_d;
                    end
                end

                assign wregs[gi*DW +: DW] = '0;
                assign rd_val[gi]         = val_q;
                assign w1c_any[gi]        = |val_q;
            end else begin : g_ro
                // RO and reserved: no storage, writes are accepted and
                // ignored, reads return the live input.
                assign wregs[gi*DW +: DW] = '0;
                assign rd_val[gi]         = rregs[gi*DW +: DW];
                assign w1c_any[gi]        = 1'b0;
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Read path, write-error and interrupt flops
    // -----------------------------------------------------------------------
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rdata_d;
    logic          rvalid_q;
    logic          rvalid_d;
    logic          rerr_q;
    logic          rerr_d;
    logic          werr_q;
    logic          werr_d;
    logic          irq_q;
    logic          irq_d;
    logic [DW-1:0] rd_sel;

    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NU; i++) begin
            if (rhit[i]) begin
                rd_sel = rd_val[i];
            end
        end

        rvalid_d = ren;
        rdata_d  = rdata_q;
        rerr_d   = 1'b0;
        if (ren) begin
            if (|rhit) begin
                rdata_d = rd_sel;
            end else begin
                rdata_d = '0;
                rerr_d  = 1'b1;
            end
        end

        // Hits on RO/reserved registers are not errors.
        werr_d = wen && !(|whit);
        irq_d  = |w1c_any;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
            werr_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            rerr_q   <= rerr_d;
            werr_q   <= werr_d;
            irq_q    <= irq_d;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign rerr   = rerr_q;
    assign werr   = werr_q;
    assign irq    = irq_q;

endmodule

// File: tb/tb_args_regbank.sv
`timescale 1ns/1ps
module tb_args_regbank;

    localparam int           NU = 4;
    localparam int           AW = 32;
    localparam int           DW = 32;
    // reg0 RW, reg1 RW, reg2 W1C, reg3 RO
    localparam logic [7:0]   TP = 8'b00_10_01_01;
    localparam logic [127:0] DV = {32'h0, 32'h0, 32'h1122_3344, 32'h0};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
`ifdef ARGS_REGBANK_SHADOW_EN
    logic          commit = 1'b0;
`endif
    logic [127:0]  rregs = '0;
    logic [127:0]  wregs;
    logic          wen = 1'b0;
    logic [31:0]   waddr = '0;
    logic [31:0]   wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          werr;
    logic          ren = 1'b0;
    logic [31:0]   raddr = '0;
    logic          rvalid;
    logic [31:0]   rdata;
    logic          rerr;
    logic          irq;

    always #5 clk = ~clk;

    args_regbank #(
        .BA(16'h0000), .NU(NU), .AW(AW), .DW(DW), .TP(TP), .DV(DV)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef ARGS_REGBANK_SHADOW_EN
        .commit(commit),
`endif
        .rregs(rregs),
        .wregs(wregs),
        .wen(wen),
        .waddr(waddr),
        .wdata(wdata),
        .wstrb(wstrb),
        .werr(werr),
        .ren(ren),
        .raddr(raddr),
        .rvalid(rvalid),
        .rdata(rdata),
        .rerr(rerr),
        .irq(irq)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic [31:0] addr;
    } rd_exp_t;

    rd_exp_t     rd_q[$];
    logic [31:0] werr_q[$];
    int          tests = 0;
    int          fails = 0;

    // Expected wregs slice 0 and expected read-back of reg0
    logic [31:0] exp_w0 = 32'h0;
    logic [31:0] exp_r0 = 32'h0;

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        rd_exp_t     e;
        logic [31:0] wa;
        if (rvalid === 1'b1) begin
            tests++;
            if (rd_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_rvalid: got rvalid=1 rdata=%h, expected no read in flight", rdata);
            end else begin
                e = rd_q.pop_front();
                if (rdata !== e.data || rerr !== e.err) begin
                    fails++;
                    $display("FAIL read addr=%h: got data=%h err=%b, expected data=%h err=%b",
                             e.addr, rdata, rerr, e.data, e.err);
                end else begin
                    $display("[TB] read  addr=%h data=%h err=%b ok", e.addr, rdata, rerr);
                end
            end
        end else if (rerr !== 1'b0) begin
            tests++;
            fails++;
            $display("FAIL rerr_idle: got rerr=%b with rvalid=0, expected 0", rerr);
        end
        if (werr === 1'b1) begin
            tests++;
            if (werr_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_werr: got werr=1, expected 0");
            end else begin
                wa = werr_q.pop_front();
                $display("[TB] werr  addr=%h ok", wa);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input bit miss);
        wen   = 1'b1;
        waddr = a;
        wdata = d;
        wstrb = s;
        if (miss) werr_q.push_back(a);
        step();
        wen = 1'b0;
        $display("[TB] write addr=%h data=%h strb=%b", a, d, s);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic e);
        ren   = 1'b1;
        raddr = a;
        rd_q.push_back('{data: d, err: e, addr: a});
        step();
        ren = 1'b0;
        chk("rvalid_latency", {127'h0, rvalid}, 128'h1);
    endtask

    function automatic logic [127:0] exp_wregs();
        return {32'h0, 32'h0, 32'h1122_3344, exp_w0};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        // Reset state
        repeat (3) step();
        chk("reset_wregs", wregs, DV);
        chk("reset_rvalid", {127'h0, rvalid}, 128'h0);
        chk("reset_rdata", {96'h0, rdata}, 128'h0);
        chk("reset_werr", {127'h0, werr}, 128'h0);
        chk("reset_irq", {127'h0, irq}, 128'h0);

        // First ren right after reset release
        rst = 1'b0;
        rd(32'h4, 32'h1122_3344, 1'b0);

        // RW byte-strobed write
        wr(32'h0, 32'hA5A5_A5A5, 4'b0011, 1'b0);
        exp_r0 = 32'h0000_A5A5;
`ifndef ARGS_REGBANK_SHADOW_EN
        exp_w0 = 32'h0000_A5A5;
`endif
        chk("rw_strobe_wregs", wregs, exp_wregs());
        rd(32'h0, exp_r0, 1'b0);
        step();

`ifdef ARGS_REGBANK_SHADOW_EN
        wr(32'h0, 32'h12, 4'hF, 1'b0);
        exp_r0 = 32'h12;
        chk("shadow_hold", wregs, exp_wregs());
        rd(32'h0, exp_r0, 1'b0);
        commit = 1'b1;
        step();
        commit = 1'b0;
        exp_w0 = 32'h12;
        chk("shadow_commit", wregs, exp_wregs());
        wr(32'h0, 32'h56, 4'hF, 1'b0);
        chk("shadow_hold2", wregs, exp_wregs());
        commit = 1'b1;
        wr(32'h0, 32'h78, 4'hF, 1'b0);
        commit = 1'b0;
        exp_w0 = 32'h56;
        exp_r0 = 32'h78;
        chk("commit_with_write", wregs, exp_wregs());
        rd(32'h0, exp_r0, 1'b0);
        commit = 1'b1;
        step();
        commit = 1'b0;
        exp_w0 = 32'h78;
        chk("commit_later", wregs, exp_wregs());
`else
        wr(32'h0, 32'h1234_5678, 4'b1100, 1'b0);
        exp_r0 = 32'h1234_A5A5;
        exp_w0 = 32'h1234_A5A5;
        chk("rw_strobe_hi", wregs, exp_wregs());
        rd(32'h0, exp_r0, 1'b0);
`endif

        // Write to RO register: no effect, no werr
        wr(32'hC, 32'hFFFF_FFFF, 4'hF, 1'b0);
        chk("ro_write_wregs", wregs, exp_wregs());

        // W1C set and irq latency
        rregs[95:64] = 32'h5;
        step();
        rregs[95:64] = 32'h0;
        chk("irq_not_yet", {127'h0, irq}, 128'h0);
        rd(32'h8, 32'h5, 1'b0);
        chk("irq_rise", {127'h0, irq}, 128'h1);
        wr(32'h8, 32'h1, 4'hF, 1'b0);
        chk("irq_stays", {127'h0, irq}, 128'h1);
        rd(32'h8, 32'h4, 1'b0);
        wr(32'h8, 32'h4, 4'hF, 1'b0);
        rd(32'h8, 32'h0, 1'b0);
        chk("irq_fall", {127'h0, irq}, 128'h0);

        // Same-cycle set and clear of bit 0: set wins
        rregs[64] = 1'b1;
        wr(32'h8, 32'h1, 4'hF, 1'b0);
        rregs[64] = 1'b0;
        rd(32'h8, 32'h1, 1'b0);
        // Clear with byte 0 strobe off: no effect
        wr(32'h8, 32'h1, 4'b1110, 1'b0);
        rd(32'h8, 32'h1, 1'b0);
        wr(32'h8, 32'h1, 4'hF, 1'b0);
        rd(32'h8, 32'h0, 1'b0);

        // Misses
        rd(32'h10, 32'h0, 1'b1);
        rd(32'h2, 32'h0, 1'b1);
        wr(32'h10, 32'hFFFF_FFFF, 4'hF, 1'b1);
        step();
        chk("miss_write_wregs", wregs, exp_wregs());
        rd(32'h0, exp_r0, 1'b0);

        // RO read samples rregs in the ren cycle, then rdata holds
        rregs[127:96] = 32'hCAFE_BABE;
        rd(32'hC, 32'hCAFE_BABE, 1'b0);
        rregs[127:96] = 32'h0;
        step();
        chk("rdata_hold", {96'h0, rdata}, {96'h0, 32'hCAFE_BABE});

        // Back-to-back reads over all four registers
        rregs[127:96] = 32'h0BAD_F00D;
        for (int i = 0; i < 4; i++) begin
            ren   = 1'b1;
            raddr = 32'(i * 4);
            case (i)
                0:       rd_q.push_back('{data: exp_r0,        err: 1'b0, addr: 32'h0});
                1:       rd_q.push_back('{data: 32'h1122_3344, err: 1'b0, addr: 32'h4});
                2:       rd_q.push_back('{data: 32'h0,         err: 1'b0, addr: 32'h8});
                default: rd_q.push_back('{data: 32'h0BAD_F00D, err: 1'b0, addr: 32'hC});
            endcase
            step();
        end
        ren = 1'b0;
        step();
        chk("b2b_drained", {96'h0, 32'(rd_q.size())}, 128'h0);
        rregs[127:96] = 32'h0;

        // Reset asserted while a read is in flight
        ren   = 1'b1;
        raddr = 32'h0;
        #2 rst = 1'b1;
        step();
        ren = 1'b0;
        chk("rst_no_rvalid", {127'h0, rvalid}, 128'h0);
        step();
        rst = 1'b0;
        step();
        chk("rst_no_rvalid_after", {127'h0, rvalid}, 128'h0);
        exp_w0 = 32'h0;
        exp_r0 = 32'h0;
        chk("rst_wregs", wregs, DV);
        rd(32'h0, 32'h0, 1'b0);
        step();

        chk("rd_queue_empty", {96'h0, 32'(rd_q.size())}, 128'h0);
        chk("werr_queue_empty", {96'h0, 32'(werr_q.size())}, 128'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench to finish");
        $fatal(1);
    end

endmodule
